// File: rtl/bram_slave_port_if.sv
// Serial interconnect lines between a bus master port and a BRAM slave.
// master modport drives request/write bits; slave modport returns read bits.
interface bram_slave_port_if;
  logic       s_master_valid;
  logic       s_master_ready;
  logic       s_read_en;
  logic       s_write_en;
  logic       s_rx_address;
  logic       s_rx_burst;
  logic       s_rx_data;
  logic [5:0] s_slave_delay;
  logic       s_tx_data;
  logic       s_slave_valid;
  logic       s_slave_ready;

  modport master (
    output s_master_valid, s_master_ready,
    output s_read_en, s_write_en,
    output s_rx_address, s_rx_burst,
    output s_rx_data, s_slave_delay,
    input  s_tx_data, s_slave_valid,
    input  s_slave_ready
  );

  modport slave (
    input  s_master_valid, s_master_ready,
    input  s_read_en, s_write_en,
    input  s_rx_address, s_rx_burst,
    input  s_rx_data, s_slave_delay,
    output s_tx_data, s_slave_valid,
    output s_slave_ready
  );
endinterface

// File: rtl/bram_slave_port.sv
// 4k x 8 BRAM slave: deserialises addr/burst/wdata, serialises rdata.
// Ports: clk, rst (async low), bus (slave modport), busy. Opt: BRAM_SLAVE_DELAY_EN.
module bram_slave_port #(
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 12
) (
  input  logic clk,
  input  logic rst,
  bram_slave_port_if.slave bus,
  output logic busy
);
  localparam int MAXL = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
  localparam int CW   = $clog2(MAXL + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR   = 3'd1;
  localparam logic [2:0] WDATA  = 3'd2;
  localparam logic [2:0] WSTORE = 3'd3;
  localparam logic [2:0] RFETCH = 3'd4;
  localparam logic [2:0] RDATA  = 3'd6;
  localparam logic [2:0] DONE   = 3'd7;
`ifdef BRAM_SLAVE_DELAY_EN
  localparam logic [2:0] RWAIT  = 3'd5;
  logic [5:0] dly;
`else
  logic unused_dly;
  assign unused_dly = ^bus.s_slave_delay;
`endif

  logic [2:0]           state;
  logic [ADDR_LEN-1:0]  addr;
  logic [BURST_LEN-1:0] burst;
  logic [BURST_LEN-1:0] burst_nx;
  logic [BURST_LEN-1:0] words_left;
  logic [CW-1:0]        bitcnt;
  logic                 is_rd;
  logic [DATA_LEN-1:0]  wsh;
  logic [DATA_LEN-1:0]  tsh;
  logic [DATA_LEN-1:0]  mem [2**ADDR_LEN];
  logic                 start;

  assign start = bus.s_master_valid &
                 (bus.s_read_en ^ bus.s_write_en);

  // burst field is shorter than or equal to addr: stop shifting it early
  assign burst_nx = (bitcnt < CW'(BURST_LEN)) ?
                    {bus.s_rx_burst, burst[BURST_LEN-1:1]} :
                    burst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr       <= '0;
      burst      <= '0;
      words_left <= '0;
      bitcnt     <= '0;
      is_rd      <= 1'b0;
      wsh        <= '0;
      tsh        <= '0;
`ifdef BRAM_SLAVE_DELAY_EN
      dly        <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            addr   <= {bus.s_rx_address, addr[ADDR_LEN-1:1]};
            burst  <= {bus.s_rx_burst, burst[BURST_LEN-1:1]};
            is_rd  <= bus.s_read_en;
            bitcnt <= CW'(1);
            state  <= ADDR;
          end
        end
        ADDR: begin
          if (bus.s_master_valid) begin
            addr  <= {bus.s_rx_address, addr[ADDR_LEN-1:1]};
            burst <= burst_nx;
            if (bitcnt == CW'(ADDR_LEN - 1)) begin
              bitcnt     <= '0;
              words_left <= (burst_nx == '0) ?
                            BURST_LEN'(1) : burst_nx;
              state      <= is_rd ? RFETCH : WDATA;
            end else begin
              bitcnt <= bitcnt + CW'(1);
            end
          end
        end
        WDATA: begin
          if (bus.s_master_valid) begin
            wsh <= {bus.s_rx_data, wsh[DATA_LEN-1:1]};
            if (bitcnt == CW'(DATA_LEN - 1)) begin
              bitcnt <= '0;
              state  <= WSTORE;
            end else begin
              bitcnt <= bitcnt + CW'(1);
            end
          end
        end
        WSTORE: begin
          addr       <= addr + ADDR_LEN'(1);
          words_left <= words_left - BURST_LEN'(1);
          state      <= (words_left == BURST_LEN'(1)) ?
                        DONE : WDATA;
        end
        RFETCH: begin
          tsh    <= mem[addr];
          bitcnt <= '0;
`ifdef BRAM_SLAVE_DELAY_EN
          dly    <= bus.s_slave_delay;
          state  <= (bus.s_slave_delay != '0) ?
                    RWAIT : RDATA;
        end
        RWAIT: begin
          dly <= dly - 6'd1;
          if (dly == 6'd1) state <= RDATA;
`else
          state  <= RDATA;
`endif
        end
        RDATA: begin
          if (bus.s_master_ready) begin
            tsh <= tsh >> 1;
            if (bitcnt == CW'(DATA_LEN - 1)) begin
              bitcnt     <= '0;
              addr       <= addr + ADDR_LEN'(1);
              words_left <= words_left - BURST_LEN'(1);
              state      <= (words_left == BURST_LEN'(1)) ?
                            DONE : RFETCH;
            end else begin
              bitcnt <= bitcnt + CW'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM has no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (state == WSTORE) mem[addr] <= wsh;
  end

  assign bus.s_slave_ready = (state == IDLE) |
                             (state == ADDR) |
                             (state == WDATA);
  assign bus.s_slave_valid = (state == RDATA);
  assign bus.s_tx_data     = (state == RDATA) & tsh[0];
  assign busy              = (state != IDLE);
endmodule

// File: doc/bram_slave_port.md
Name: bram_slave_port

Overview:
- Serial-bus slave endpoint that sits directly downstream of the bus interconnect's slave port. It is the 4k x 8 block-RAM slave behind the s1/s2/s3 port group.
- Deserialises the address, burst count and write data arriving on 1-bit interconnect lines, and executes single or burst accesses to an internal RAM.
- Serialises read data back to the master through the valid/ready handshake.

Parameters:
- ADDR_LEN, 12, address width in bits; RAM depth is 2^ADDR_LEN words.
- DATA_LEN, 8, RAM word width and number of bits per serial data word.
- BURST_LEN, 12, burst-count width in bits; must be <= ADDR_LEN.

Ports:
- clk  input  1  bus clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- s_master_valid  input  1  master is driving a valid address or write-data bit this cycle.
- s_master_ready  input  1  master accepts the current read-data bit this cycle.
- s_read_en  input  1  transaction is a read.
- s_write_en  input  1  transaction is a write.
- s_rx_address  input  1  serial address, LSB first.
- s_rx_burst  input  1  serial burst count, LSB first.
- s_rx_data  input  1  serial write data, LSB first.
- s_slave_delay  input  6  per-word read wait, in cycles; used only with the optional feature.
- s_tx_data  output  1  serial read data, LSB first.
- s_slave_valid  output  1  s_tx_data is valid this cycle.
- s_slave_ready  output  1  slave is accepting serial input bits this cycle.
- busy  output  1  a transaction is in progress.

Behaviour:
- Reset: asynchronous, active-low. Clears the FSM to IDLE and clears all counters and shift registers. RAM contents are preserved.
- Output values while in reset and in IDLE: s_slave_ready=1, s_slave_valid=0, s_tx_data=0, busy=0.
- Reset asserted mid-transaction aborts it immediately. A partially shifted write word is discarded and never written.
- FSM states: IDLE, ADDR, WDATA, WSTORE, RFETCH, RWAIT (RWAIT exists only with the macro), RDATA, DONE.
- IDLE:
  - Start condition: s_master_valid=1 with exactly one of s_read_en/s_write_en set.
  - On start: capture address bit0 and burst bit0 in that same cycle, latch the direction, set bitcnt=1, go to ADDR.
  - Both enables set, or neither: ignore and stay in IDLE.
- ADDR:
  - On each cycle with s_master_valid=1, capture the next address bit. While bitcnt < BURST_LEN, also capture the next burst bit in the same cycle.
  - s_master_valid=0 pauses shifting without losing state.
  - After ADDR_LEN bits have been captured, go to WDATA (write) or RFETCH (read). Load words_left = burst, with a burst value of 0 treated as 1.
- s_slave_ready=1 only in IDLE, ADDR and WDATA; it is 0 in all other states.
- busy=1 in every state except IDLE.
- WDATA:
  - Shift in one s_rx_data bit per cycle with s_master_valid=1.
  - After DATA_LEN bits, go to WSTORE.
- WSTORE (1 cycle):
  - Write mem[addr] = the shifted word.
  - addr = (addr+1) mod 2^ADDR_LEN, so access wraps from address 4095 to 0.
  - Decrement words_left. Go to DONE if words_left reaches 0, otherwise return to WDATA.
- RFETCH (1 cycle):
  - Perform a synchronous RAM read of mem[addr] and load it into the tx shift register.
  - Go to RDATA (or RWAIT when the macro is enabled and the delay is nonzero).
- RDATA:
  - s_slave_valid=1 and s_tx_data = shreg[0].
  - On each cycle with s_master_ready=1: shift right and increment bitcnt.
  - After DATA_LEN accepted bits: advance addr (wrapping) and decrement words_left. Go to DONE if words_left is 0, otherwise go to RFETCH; s_slave_valid drops for that fetch cycle.
- DONE (1 cycle): all handshake outputs low, then go to IDLE.
- Minimum latency:
  - Single write: ADDR_LEN+DATA_LEN+2 cycles from the start cycle back to IDLE.
  - Single read: the first data bit is valid ADDR_LEN+1 cycles after the start cycle.
- Changes to s_read_en/s_write_en after the start cycle are ignored.

Optional Feature:
- Macro name: BRAM_SLAVE_DELAY_EN.
- When defined:
  - Before every read word, the FSM waits in RWAIT for s_slave_delay cycles, sampled on entry to RFETCH, with s_slave_ready=0 and s_slave_valid=0.
  - A delay of 0 skips RWAIT.
  - Writes are unaffected.
- When undefined: the RWAIT state and its counter are absent, s_slave_delay is unused, and read timing is exactly as in Behaviour.

Test Plan:
- Single write, then single read. Write addr 0x123, burst 0, data 0xA5. Then read addr 0x123 with s_master_ready held at 1. Required: s_tx_data carries bits 1,0,1,0,0,1,0,1 on consecutive valid cycles; the write returns to IDLE after 22 cycles.
- Burst with wrap. Write addr 0xFFE, burst 3, data 0x11, 0x22, 0x33. Then burst-read addr 0xFFE. Required: returned words are 0x11, 0x22, 0x33, with the third word coming from addr 0x000.
- Handshake stalls. During the address phase, drop s_master_valid for 5 cycles. During the read, toggle s_master_ready 1-0-1-0. Required: no bits are lost or duplicated, and the read data matches the RAM.
- Illegal start. Assert s_master_valid with both s_read_en and s_write_en set. Required: the block stays in IDLE with busy=0 and the RAM is unchanged.
- Reset mid-write. Assert rst=0 after 4 data bits of a write to 0x050. Required: all outputs return to their reset values at once, and a later read of 0x050 returns the previous contents.
- Macro build (BRAM_SLAVE_DELAY_EN defined). Burst-read 2 words with s_slave_delay=3. Required: exactly 3 extra cycles with s_slave_valid=0 before each word.
